seven_seg_mux_driver: RTL and testbench

Parametrised successor to the single-digit score decoder. Accepts a binary value, scales it by a constant divisor, and converts it to BCD sequentially (double-dabble, one bit per clock). It then time-multiplexes NUM_DIGITS active-low seven-segment digits on a shared segment bus. It sits between game/score logic and the board's common-anode display pins, and adds leading-zero blanking, an overflow indication and a start/busy/done handshake.

---
 rtl/seven_seg_pkg.sv | 55 +++++
 rtl/seven_seg_mux_driver_bin2bcd.sv | 71 +++++++
 rtl/seven_seg_mux_driver.sv | 108 ++++++++++
 tb/tb_seven_seg_mux_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, segment encoding and converter state type for the
// multiplexed seven-segment score display.
package seven_seg_pkg;

  // Segment vectors are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed to hold the largest w-bit unsigned value.
  function automatic int bcd_digits(input int w);
    longint lim;
    longint p;
    int     d;
    lim = (longint'(1) << w) - 1;
    p   = 10;
    d   = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seven_seg_mux_driver_bin2bcd.sv
// Sequential double-dabble converter: one input bit per clock, with a
// start/busy/done handshake. start is only honoured while idle.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output conv_state_t         state_dbg
);

  localparam int CNT_W = $clog2(IN_W + 1);

  conv_state_t         state, state_nxt;
  logic [IN_W-1:0]     q;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] bcd_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      if (state == IDLE && start) begin
        q   <= bin;
        bcd <= '0;
        cnt <= CNT_W'(IN_W);
      end else if (state == SHIFT) begin
        {bcd, q} <= {bcd_adj[4*DIGITS-2:0], q, 1'b0};
        cnt      <= cnt - 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Scales a binary score, converts it to BCD and scans it onto a
// common-anode multiplexed display with blanking and overflow dashes.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 8,
  parameter int SCALE_DIV   = 5,
  parameter int REFRESH_CNT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  start,
  input  logic                  blank_lz,
  input  logic                  disp_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CONV_DIGITS = (bcd_digits(VALUE_W) > NUM_DIGITS) ?
                               bcd_digits(VALUE_W) : NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_CNT);
  localparam logic [63:0] OVF_LIMIT = 64'(pow10(NUM_DIGITS));

  logic [VALUE_W-1:0]      scaled;
  logic                    ovf_pend;
  logic [4*CONV_DIGITS-1:0] conv_bcd;
  conv_state_t             conv_state;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              cur_digit;
  logic                    lz_blank;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign scaled = value / VALUE_W'(SCALE_DIV);

  bin2bcd_seq #(
    .IN_W   (VALUE_W),
    .DIGITS (CONV_DIGITS)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin       (scaled),
    .busy      (busy),
    .done      (done),
    .bcd       (conv_bcd),
    .state_dbg (conv_state)
  );

  // Overflow is judged on the scaled value when it is accepted and only
  // becomes visible together with the result it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      disp_bcd <= '0;
    end else begin
      if (start && !busy) ovf_pend <= (64'(scaled) >= OVF_LIMIT);
      if (conv_state == COMMIT) begin
        disp_bcd <= conv_bcd[4*NUM_DIGITS-1:0];
        overflow <= ovf_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(REFRESH_CNT - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    cur_digit = disp_bcd[4*idx +: 4];
    lz_blank  = blank_lz && (idx != '0) && ((disp_bcd >> (4*idx)) == '0);
    if (overflow)      seg_nxt = SEG_DASH;
    else if (lz_blank) seg_nxt = SEG_BLANK;
    else               seg_nxt = digit_to_seg(cur_digit);
    an_nxt = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else if (!disp_en) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench: table of scored values with hand-computed digit patterns,
// plus sequences for reset, ignored start and display disable.
module tb_seven_seg_mux_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  typedef struct packed {
    logic [7:0]      value;
    logic            blz;
    logic [3:0][6:0] exp_seg;   // {digit3, digit2, digit1, digit0}
    logic [6:0]      exp_seg1;  // single-digit instance
    logic            exp_ovf1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = '0;
  logic       start = 1'b0;
  logic       blank_lz = 1'b0;
  logic       disp_en = 1'b1;

  logic       busy, done, overflow;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy1, done1, overflow1;
  logic [6:0] seg1;
  logic [0:0] an1;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs [10];

  always #5 clk = ~clk;

  seven_seg_mux_driver #(
    .NUM_DIGITS(4), .VALUE_W(8), .SCALE_DIV(5), .REFRESH_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .start(start),
    .blank_lz(blank_lz), .disp_en(disp_en), .busy(busy), .done(done),
    .overflow(overflow), .seg(seg), .an(an)
  );

  seven_seg_mux_driver #(
    .NUM_DIGITS(1), .VALUE_W(8), .SCALE_DIV(5), .REFRESH_CNT(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .start(start),
    .blank_lz(blank_lz), .disp_en(disp_en), .busy(busy1), .done(done1),
    .overflow(overflow1), .seg(seg1), .an(an1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pulses start for one cycle and measures cycles from the sampling edge to done.
  task automatic run_conv(input logic [7:0] v, output int lat, output logic busy_seen);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Over one full 16-cycle scan period each digit must appear exactly 4 times.
  task automatic check_scan(input logic [3:0][6:0] exp, input string tag);
    int hits [4];
    int zeros;
    int d;
    for (int i = 0; i < 4; i++) hits[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      zeros = 0;
      d = 0;
      for (int k = 0; k < 4; k++) begin
        if (!an[k]) begin
          zeros++;
          d = k;
        end
      end
      check({tag, "_an_onehot"}, zeros, 1);
      if (zeros == 1) begin
        hits[d]++;
        check({tag, "_seg"}, {25'b0, seg}, {25'b0, exp[d]});
      end
    end
    for (int k = 0; k < 4; k++) check({tag, "_hold"}, hits[k], 4);
  endtask

  initial begin
    int   lat;
    logic bs;
    int   pulses;

    vecs[0] = '{value: 8'd255, blz: 1'b0, exp_seg: {S0, S0, S5, S1}, exp_seg1: SD, exp_ovf1: 1'b1};
    vecs[1] = '{value: 8'd255, blz: 1'b1, exp_seg: {SB, SB, S5, S1}, exp_seg1: SD, exp_ovf1: 1'b1};
    vecs[2] = '{value: 8'd0,   blz: 1'b1, exp_seg: {SB, SB, SB, S0}, exp_seg1: S0, exp_ovf1: 1'b0};
    vecs[3] = '{value: 8'd0,   blz: 1'b0, exp_seg: {S0, S0, S0, S0}, exp_seg1: S0, exp_ovf1: 1'b0};
    vecs[4] = '{value: 8'd200, blz: 1'b1, exp_seg: {SB, SB, S4, S0}, exp_seg1: SD, exp_ovf1: 1'b1};
    vecs[5] = '{value: 8'd123, blz: 1'b0, exp_seg: {S0, S0, S2, S4}, exp_seg1: SD, exp_ovf1: 1'b1};
    vecs[6] = '{value: 8'd47,  blz: 1'b1, exp_seg: {SB, SB, SB, S9}, exp_seg1: S9, exp_ovf1: 1'b0};
    vecs[7] = '{value: 8'd50,  blz: 1'b1, exp_seg: {SB, SB, S1, S0}, exp_seg1: SD, exp_ovf1: 1'b1};
    vecs[8] = '{value: 8'd45,  blz: 1'b0, exp_seg: {S0, S0, S0, S9}, exp_seg1: S9, exp_ovf1: 1'b0};
    vecs[9] = '{value: 8'd250, blz: 1'b1, exp_seg: {SB, SB, S5, S0}, exp_seg1: SD, exp_ovf1: 1'b1};

    // Reset state while the clock runs, then first lit digit after release.
    repeat (3) @(negedge clk);
    check("rst_an", {28'b0, an}, 32'hF);
    check("rst_seg", {25'b0, seg}, {25'b0, SB});
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_an", {28'b0, an}, 32'hE);
    check("rel_seg", {25'b0, seg}, {25'b0, S0});

    for (int i = 0; i < 10; i++) begin
      blank_lz = vecs[i].blz;
      run_conv(vecs[i].value, lat, bs);
      check("busy_after_start", {31'b0, bs}, 1);
      check("done_latency", lat, 9);
      check("busy_at_done", {31'b0, busy}, 0);
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 0);
      repeat (2) @(negedge clk);
      check_scan(vecs[i].exp_seg, "scan");
      check("ovf4", {31'b0, overflow}, 0);
      check("ovf1", {31'b0, overflow1}, {31'b0, vecs[i].exp_ovf1});
      check("seg1", {25'b0, seg1}, {25'b0, vecs[i].exp_seg1});
      check("an1", {31'b0, an1}, 0);
    end

    // Second start three cycles into a conversion is ignored.
    blank_lz = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) pulses++;
      case (c)
        0: begin value = 8'd100; start = 1'b1; end
        1: start = 1'b0;
        3: begin value = 8'd200; start = 1'b1; end
        4: start = 1'b0;
        default: ;
      endcase
    end
    check("ignored_start_pulses", pulses, 1);
    check_scan({S0, S0, S2, S0}, "ignored_start");
    check("ignored_start_ovf1", {31'b0, overflow1}, 1);

    // Reset during SHIFT abandons the conversion and clears the display.
    run_conv(8'd123, lat, bs);
    repeat (2) @(negedge clk);
    value = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("async_an", {28'b0, an}, 32'hF);
    check("async_seg", {25'b0, seg}, {25'b0, SB});
    check("async_busy", {31'b0, busy}, 0);
    check("async_done", {31'b0, done}, 0);
    check("async_ovf1", {31'b0, overflow1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("post_reset_no_done", pulses, 0);
    check_scan({S0, S0, S0, S0}, "post_reset");
    disp_en = 1'b0;
    @(negedge clk);
    check("dis_an", {28'b0, an}, 32'hF);
    check("dis_seg", {25'b0, seg}, {25'b0, SB});
    check("dis_an1", {31'b0, an1}, 1);
    disp_en = 1'b1;
    @(negedge clk);
    check("reen_onehot", {31'b0, ($countones(~an) == 1)}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
